// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types for the CPU/debug memory bus arbiter.
// Arbiter FSM states, grant encodings and counter sizing helper.
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB,
      DBG_RD,
      RESP
   } arb_state_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_CPU,
      GNT_DBG
   } arb_grant_t;

   // Bits needed to hold 0..limit inclusive.
   function automatic int unsigned cnt_width(input int unsigned limit);
      return (limit < 1) ? 1 : $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of arbitration conflicts lost by the debug master.
// Clear has priority over increment; at_limit flags the forced-win point.
module arb_starve_ctr
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned LIMIT = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output logic at_limit
);

   localparam int unsigned W = cnt_width(LIMIT);
   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt;

   always_ff @(posedge clock) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != LIM)) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign at_limit = (cnt == LIM);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares a single-port synchronous memory between the CPU datapath and a
// debug/DMA master; CPU has priority, debug is forced through after repeated losses.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int unsigned AW           = 16,
   parameter int unsigned DW           = 16,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          cpu_re,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_gnt,
   output logic          dbg_rvalid,
   output logic [DW-1:0] dbg_rdata,
   output logic          mem_re,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   arb_state_t state;
   arb_grant_t grant;

   logic cpu_req;
   logic dbg_ok;
   logic at_limit;
   logic starve_inc;

   assign cpu_req = cpu_re | cpu_we;
   assign dbg_ok  = dbg_req && (state == ARB);

   // Grants are suppressed during the reset cycle so no stray access reaches memory.
   always_comb begin
      grant = GNT_NONE;
      if (!reset) begin
         if (cpu_req && dbg_ok) begin
            grant = at_limit ? GNT_DBG : GNT_CPU;
         end else if (cpu_req) begin
            grant = GNT_CPU;
         end else if (dbg_ok) begin
            grant = GNT_DBG;
         end
      end
   end

   always_comb begin
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (grant)
         GNT_CPU: begin
            mem_re    = cpu_re;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
         end
         GNT_DBG: begin
            mem_re    = ~dbg_we;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
         end
         default: ;
      endcase
   end

   assign dbg_gnt    = (grant == GNT_DBG);
   assign cpu_stall  = cpu_req && dbg_gnt;
   assign cpu_rdata  = mem_rdata;
   assign starve_inc = cpu_req && dbg_ok && (grant == GNT_CPU);

   arb_starve_ctr #(
      .LIMIT (STARVE_LIMIT)
   ) u_starve (
      .clock    (clock),
      .reset    (reset),
      .inc      (starve_inc),
      .clr      (dbg_gnt),
      .at_limit (at_limit)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= ARB;
         dbg_rdata  <= '0;
         dbg_rvalid <= 1'b0;
      end else begin
         dbg_rvalid <= 1'b0;
         case (state)
            ARB: begin
               if (dbg_gnt && !dbg_we) begin
                  state <= DBG_RD;
               end
            end
            DBG_RD: begin
               dbg_rdata  <= mem_rdata;
               dbg_rvalid <= 1'b1;
               state      <= RESP;
            end
            RESP: begin
               state <= ARB;
            end
            default: begin
               state <= ARB;
            end
         endcase
      end
   end

   a_cpu_rw_excl: assert property (@(posedge clock) disable iff (reset) !(cpu_re && cpu_we));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomized checks of mem_bus_arbiter against a cycle-level
// reference model of the arbitration rules plus a shadow memory scoreboard.
module tb_mem_bus_arbiter;

   localparam int LIMIT = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_re = 1'b0, cpu_we = 1'b0;
   logic [15:0] cpu_addr = '0, cpu_wdata = '0;
   logic [15:0] cpu_rdata;
   logic        cpu_stall;
   logic        dbg_req = 1'b0, dbg_we = 1'b0;
   logic [15:0] dbg_addr = '0, dbg_wdata = '0;
   logic        dbg_gnt, dbg_rvalid;
   logic [15:0] dbg_rdata;
   logic        mem_re, mem_we;
   logic [15:0] mem_addr, mem_wdata;
   logic [15:0] mem_rdata = '0;

   logic [15:0] mem_arr [0:65535] = '{default: '0};
   logic [15:0] ref_mem [0:65535] = '{default: '0};
   int          n_mem_wr = 0;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          starve = 0, busy = 0, cyc = 0, rv_at = -10, n_exp_wr = 0;
   logic [15:0] pend = '0, dbg_rdata_m = '0, rd_exp = '0;
   logic        rd_pend = 1'b0;
   logic        m_cpu_req, m_dbg_can, e_dwin, e_cwin;
   logic        cpu_hold = 1'b0, dbg_hold = 1'b0;

   always #5 clock = ~clock;

   mem_bus_arbiter #(
      .AW           (16),
      .DW           (16),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .cpu_re     (cpu_re),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_stall  (cpu_stall),
      .dbg_req    (dbg_req),
      .dbg_we     (dbg_we),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
      .mem_re     (mem_re),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // single-port synchronous memory: write this cycle, read data next cycle
   always @(posedge clock) begin
      if (mem_we) begin
         mem_arr[mem_addr] <= mem_wdata;
         n_mem_wr <= n_mem_wr + 1;
      end
      if (mem_re) mem_rdata <= mem_arr[mem_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   // Wait to mid-cycle and compare every output against the model.
   task automatic eval();
      logic        e_re, e_we;
      logic [15:0] e_addr, e_wdata;
      @(negedge clock);
      m_cpu_req = cpu_re | cpu_we;
      if (reset) begin
         e_dwin = 1'b0;
         e_cwin = 1'b0;
         chk("rst_gnt",   dbg_gnt,   0);
         chk("rst_stall", cpu_stall, 0);
         chk("rst_re",    mem_re,    0);
         chk("rst_we",    mem_we,    0);
      end else begin
         m_dbg_can = dbg_req && (busy == 0);
         e_dwin    = m_dbg_can && (!m_cpu_req || starve == LIMIT);
         e_cwin    = m_cpu_req && !e_dwin;
         e_re      = (e_cwin && cpu_re) || (e_dwin && !dbg_we);
         e_we      = (e_cwin && cpu_we) || (e_dwin && dbg_we);
         e_addr    = e_cwin ? cpu_addr  : (e_dwin ? dbg_addr  : 16'h0);
         e_wdata   = e_cwin ? cpu_wdata : (e_dwin ? dbg_wdata : 16'h0);
         chk("dbg_gnt",    dbg_gnt,    e_dwin);
         chk("cpu_stall",  cpu_stall,  m_cpu_req && e_dwin);
         chk("mem_re",     mem_re,     e_re);
         chk("mem_we",     mem_we,     e_we);
         chk("mem_addr",   mem_addr,   e_addr);
         chk("mem_wdata",  mem_wdata,  e_wdata);
         chk("dbg_rvalid", dbg_rvalid, (cyc == rv_at));
         chk("dbg_rdata",  dbg_rdata,  dbg_rdata_m);
         if (rd_pend) chk("cpu_rdata", cpu_rdata, rd_exp);
      end
   endtask

   // Advance the model across the clock edge.
   task automatic adv();
      if (reset) begin
         starve = 0; busy = 0; rv_at = -10; dbg_rdata_m = '0; rd_pend = 1'b0;
      end else begin
         if (cyc == rv_at - 1) dbg_rdata_m = pend;
         if (e_dwin) starve = 0;
         else if (m_cpu_req && m_dbg_can) starve = (starve < LIMIT) ? starve + 1 : LIMIT;
         if (busy > 0) busy--;
         rd_pend = e_cwin && cpu_re;
         if (rd_pend) rd_exp = ref_mem[cpu_addr];
         if (e_cwin && cpu_we) begin
            ref_mem[cpu_addr] = cpu_wdata;
            n_exp_wr++;
         end
         if (e_dwin && dbg_we) begin
            ref_mem[dbg_addr] = dbg_wdata;
            n_exp_wr++;
         end
         if (e_dwin && !dbg_we) begin
            busy  = 2;
            rv_at = cyc + 2;
            pend  = ref_mem[dbg_addr];
         end
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d);
      idle(); cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
      eval(); chk("cpuwr_stall", cpu_stall, 0); adv();
   endtask

   task automatic cpu_rd(input logic [15:0] a);
      idle(); cpu_re = 1'b1; cpu_addr = a;
      eval(); chk("cpurd_stall", cpu_stall, 0); adv();
   endtask

   initial begin
      int unsigned k;
      // reset
      idle(); reset = 1'b1;
      eval(); adv();
      eval(); adv();
      reset = 1'b0;
      eval();
      chk("rst_rdata",  dbg_rdata,  0);
      chk("rst_rvalid", dbg_rvalid, 0);
      chk("rst_addr",   mem_addr,   0);
      adv();

      // CPU-only traffic; also preloads debug targets
      cpu_wr(16'h0020, 16'h1234);
      cpu_wr(16'h0030, 16'h5A5A);
      cpu_rd(16'h0010);
      cpu_wr(16'h0010, 16'hBEEF);
      cpu_rd(16'h0010);
      idle(); eval(); chk("cpu_rd_beef", cpu_rdata, 16'hBEEF); adv();

      // debug-only read
      idle(); dbg_req = 1'b1; dbg_addr = 16'h0020;
      eval(); chk("dbgrd_gnt", dbg_gnt, 1); adv();
      idle(); eval(); chk("dbgrd_n1_rvalid", dbg_rvalid, 0); adv();
      eval(); chk("dbgrd_n2_rvalid", dbg_rvalid, 1); chk("dbgrd_data", dbg_rdata, 16'h1234); adv();
      eval(); chk("dbgrd_hold_rvalid", dbg_rvalid, 0); chk("dbgrd_hold", dbg_rdata, 16'h1234); adv();

      // starvation: CPU reads every cycle against a held debug write
      idle(); dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0050; dbg_wdata = 16'hCAFE;
      for (int i = 0; i < 5; i++) begin
         cpu_re = 1'b1; cpu_addr = 16'h0040 + 16'(i);
         eval();
         chk("starve_gnt",   dbg_gnt,   (i == 4));
         chk("starve_stall", cpu_stall, (i == 4));
         adv();
      end
      dbg_req = 1'b0; dbg_we = 1'b0;
      eval(); chk("stalled_rd_stall", cpu_stall, 0); chk("stalled_rd_addr", mem_addr, 16'h0044); adv();
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0051; dbg_wdata = 16'h0001; cpu_addr = 16'h0045;
      eval(); chk("starve_clr", dbg_gnt, 0); adv();
      cpu_re = 1'b0;
      eval(); chk("starve_solo_gnt", dbg_gnt, 1); adv();

      // debug read overlapped with a CPU write during DBG_RD / RESP
      idle(); dbg_req = 1'b1; dbg_addr = 16'h0030;
      eval(); chk("ovl_gnt", dbg_gnt, 1); adv();
      dbg_we = 1'b1; dbg_addr = 16'h0032; dbg_wdata = 16'h7777;
      cpu_we = 1'b1; cpu_addr = 16'h0031; cpu_wdata = 16'h1111;
      eval(); chk("ovl_ignored", dbg_gnt, 0); chk("ovl_cpu_we", mem_we, 1); adv();
      cpu_we = 1'b0;
      eval(); chk("ovl_resp_gnt", dbg_gnt, 0); chk("ovl_rvalid", dbg_rvalid, 1);
      chk("ovl_rdata", dbg_rdata, 16'h5A5A); adv();
      eval(); chk("ovl_next_gnt", dbg_gnt, 1); adv();
      idle(); cpu_re = 1'b1; cpu_addr = 16'h0031;
      eval(); adv();
      idle(); eval(); chk("ovl_cpu_rd", cpu_rdata, 16'h1111); adv();

      // reset during DBG_RD aborts the read
      idle(); dbg_req = 1'b1; dbg_addr = 16'h0020;
      eval(); chk("abort_gnt", dbg_gnt, 1); adv();
      idle(); reset = 1'b1;
      eval(); adv();
      reset = 1'b0;
      eval();
      chk("abort_rvalid", dbg_rvalid, 0); chk("abort_rdata", dbg_rdata, 0);
      chk("abort_gnt0", dbg_gnt, 0); chk("abort_stall", cpu_stall, 0);
      chk("abort_re", mem_re, 0); chk("abort_we", mem_we, 0);
      adv();
      eval(); chk("abort_no_late_rvalid", dbg_rvalid, 0); adv();
      dbg_req = 1'b1; dbg_addr = 16'h0030;
      eval(); chk("fresh_gnt", dbg_gnt, 1); adv();
      idle(); eval(); adv();
      eval(); chk("fresh_rvalid", dbg_rvalid, 1); chk("fresh_rdata", dbg_rdata, 16'h5A5A); adv();

      // randomized mixed traffic
      idle(); cpu_hold = 1'b0; dbg_hold = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if (!cpu_hold) begin
            k = $urandom_range(0, 3);
            cpu_re    = (k == 1) || (k == 3);
            cpu_we    = (k == 2);
            cpu_addr  = 16'h0100 + 16'($urandom_range(0, 15));
            cpu_wdata = 16'($urandom);
         end
         if (!dbg_hold) begin
            dbg_req   = 1'($urandom_range(0, 1));
            dbg_we    = 1'($urandom_range(0, 1));
            dbg_addr  = 16'h0100 + 16'($urandom_range(0, 15));
            dbg_wdata = 16'($urandom);
         end
         eval();
         adv();
         cpu_hold = m_cpu_req && e_dwin;
         dbg_hold = dbg_req && !e_dwin;
      end
      idle(); eval(); adv();
      eval(); adv();

      chk("write_count", n_mem_wr, n_exp_wr);
      for (int a = 0; a < 512; a++) begin
         chk("mem_contents", mem_arr[a], ref_mem[a]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
